uib_arbiter: RTL and testbench

//  Round-robin master arbiter for the uib bus interconnect. Chooses which master owns the bus.

---
 rtl/uib_arbiter_pkg.sv | 30 +++
 rtl/uib_arbiter_if.sv | 44 ++++
 rtl/uib_arbiter_rr_pick.sv | 56 +++++
 rtl/uib_arbiter.sv | 170 +++++++++++++++++
 tb/tb_uib_arbiter.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/uib_arbiter_pkg.sv
// ============================================================================
// Module  : uib_pkg
// Brief   : Shared types and defaults for the uib round-robin master arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef MASTER_SIZE
`define MASTER_SIZE 4
`endif

package uib_pkg;

  // Arbiter FSM: IDLE picks, BUSY holds the grant, TURN is the one-cycle gap
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_TURN = 2'd2
  } arb_state_t;

  localparam int UIB_ARB_TIMEOUT_DEF = 255;

  // Grant index width for a given master count (never zero)
  function automatic int uib_idx_w(input int n);
    return ($clog2(n) > 0) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uib_arbiter_if.sv
// ============================================================================
// Module  : uib_arbiter_if
// Brief   : Request/grant bundle between uib masters and the arbiter.
//           slave modport = arbiter side, master modport = requester side.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface uib_arbiter_if #(
  parameter int N_MASTER = 4,
  parameter int IDX_W    = 2
);

  logic [N_MASTER-1:0] req_i;
  logic                slave_ready_i;
  logic [N_MASTER-1:0] gnt_o;
  logic [IDX_W-1:0]    gnt_idx_o;
  logic                gnt_valid_o;
  logic                done_o;
  logic                timeout_o;

  modport master (
    output req_i,
    output slave_ready_i,
    input  gnt_o,
    input  gnt_idx_o,
    input  gnt_valid_o,
    input  done_o,
    input  timeout_o
  );

  modport slave (
    input  req_i,
    input  slave_ready_i,
    output gnt_o,
    output gnt_idx_o,
    output gnt_valid_o,
    output done_o,
    output timeout_o
  );

endinterface

`default_nettype wire

// File: rtl/uib_arbiter_rr_pick.sv
// ============================================================================
// Module  : rr_pick
// Brief   : Combinational round-robin picker. Rotates the request vector so
//           the pointer lands at bit 0, takes the lowest set bit, then rotates
//           the one-hot result back. Index wrap uses an explicit compare so a
//           non-power-of-2 master count is handled correctly.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
  parameter int N_MASTER = 4,
  parameter int IDX_W    = 2
) (
  input  wire logic [N_MASTER-1:0] req,
  input  wire logic [IDX_W-1:0]    ptr,
  output logic      [N_MASTER-1:0] onehot,
  output logic      [IDX_W-1:0]    idx,
  output logic                     any
);

  logic [2*N_MASTER-1:0] w_req_dbl;
  logic [N_MASTER-1:0]   w_req_rot;
  logic [N_MASTER-1:0]   w_oh_rot;
  logic [2*N_MASTER-1:0] w_oh_dbl;
  logic [IDX_W-1:0]      w_enc;
  logic                  w_found;
  logic [IDX_W:0]        w_sum;

  // Rotate, priority-encode from the pointer position, rotate back
  always_comb begin
    w_req_dbl = {req, req} >> ptr;
    w_req_rot = w_req_dbl[N_MASTER-1:0];
    w_enc     = '0;
    w_found   = 1'b0;
    w_oh_rot  = '0;
    for (int i = 0; i < N_MASTER; i++) begin
      if (!w_found && w_req_rot[i]) begin
        w_found     = 1'b1;
        w_enc       = IDX_W'(i);
        w_oh_rot[i] = 1'b1;
      end
    end
    w_oh_dbl = {w_oh_rot, w_oh_rot} << ptr;
    onehot   = w_oh_dbl[2*N_MASTER-1:N_MASTER];
    w_sum    = {1'b0, w_enc} + {1'b0, ptr};
    if (w_sum >= (IDX_W+1)'(N_MASTER)) begin
      w_sum = w_sum - (IDX_W+1)'(N_MASTER);
    end
    idx = w_sum[IDX_W-1:0];
    any = w_found;
  end

endmodule

`default_nettype wire

// File: rtl/uib_arbiter.sv
// ============================================================================
// Module  : uib_arbiter
// Brief   : Round-robin master arbiter for the uib interconnect. A grant is
//           held until the slave returns ready or the master drops its
//           request, followed by one TURN cycle with no grant.
//           Optional macro UIB_ARB_TIMEOUT_EN adds a forced release after
//           TIMEOUT busy cycles without ready.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uib_arbiter
  import uib_pkg::*;
#(
  parameter int N_MASTER = `MASTER_SIZE,
  parameter int IDX_W    = uib_idx_w(N_MASTER),
  parameter int TIMEOUT  = UIB_ARB_TIMEOUT_DEF
) (
  input wire logic     clk,
  input wire logic     rst,
  uib_arbiter_if.slave bus
);

  arb_state_t          r_state;
  arb_state_t          w_state_nxt;

  logic [N_MASTER-1:0] r_gnt;
  logic [IDX_W-1:0]    r_gnt_idx;
  logic                r_gnt_valid;
  logic                r_done;
  logic                r_timeout;
  logic [IDX_W-1:0]    r_rr_ptr;

  logic [N_MASTER-1:0] w_gnt_nxt;
  logic [IDX_W-1:0]    w_gnt_idx_nxt;
  logic                w_done_nxt;
  logic                w_timeout_nxt;
  logic [IDX_W-1:0]    w_rr_ptr_nxt;

  logic [N_MASTER-1:0] w_pick_oh;
  logic [IDX_W-1:0]    w_pick_idx;
  logic                w_pick_any;

  logic                w_req_held;
  logic [IDX_W-1:0]    w_ptr_after;
  logic                w_complete;
  logic                w_abort;
  logic                w_expire;
  logic                w_tmo_hit;

  rr_pick #(
    .N_MASTER (N_MASTER),
    .IDX_W    (IDX_W)
  ) u_rr_pick (
    .req    (bus.req_i),
    .ptr    (r_rr_ptr),
    .onehot (w_pick_oh),
    .idx    (w_pick_idx),
    .any    (w_pick_any)
  );

  assign w_req_held  = bus.req_i[r_gnt_idx];
  // Pointer moves just past the finished master, wrapping by compare
  assign w_ptr_after = (r_gnt_idx == IDX_W'(N_MASTER-1)) ? '0 : r_gnt_idx + IDX_W'(1);

`ifdef UIB_ARB_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [TMO_W-1:0] r_tmo_cnt;

  assign w_tmo_hit = (r_tmo_cnt == TMO_W'(TIMEOUT-1));

  // Busy-cycle counter: zero outside BUSY, counts while the grant stays
  always_ff @(posedge clk) begin
    if (rst || r_state != ARB_BUSY) begin
      r_tmo_cnt <= '0;
    end else if (w_state_nxt == ARB_BUSY) begin
      r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
    end
  end
`else
  // No forced release: BUSY waits for ready or a withdrawn request
  assign w_tmo_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; withdrawal beats ready, ready beats timeout
  always_comb begin
    w_state_nxt = r_state;
    w_complete  = 1'b0;
    w_abort     = 1'b0;
    w_expire    = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (w_pick_any) begin
          w_state_nxt = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (!w_req_held) begin
          w_abort     = 1'b1;
          w_state_nxt = ARB_TURN;
        end else if (bus.slave_ready_i) begin
          w_complete  = 1'b1;
          w_state_nxt = ARB_TURN;
        end else if (w_tmo_hit) begin
          w_expire    = 1'b1;
          w_state_nxt = ARB_TURN;
        end
      end
      ARB_TURN: w_state_nxt = ARB_IDLE;
      default:  w_state_nxt = ARB_IDLE;
    endcase
  end

  // Output logic: next values for the registered grant outputs and pointer
  always_comb begin
    w_gnt_nxt     = '0;
    w_gnt_idx_nxt = '0;
    w_done_nxt    = w_complete;
    w_timeout_nxt = w_expire;
    w_rr_ptr_nxt  = r_rr_ptr;
    if (r_state == ARB_IDLE && w_state_nxt == ARB_BUSY) begin
      w_gnt_nxt     = w_pick_oh;
      w_gnt_idx_nxt = w_pick_idx;
    end else if (r_state == ARB_BUSY && w_state_nxt == ARB_BUSY) begin
      w_gnt_nxt     = r_gnt;
      w_gnt_idx_nxt = r_gnt_idx;
    end
    if (w_complete || w_abort || w_expire) begin
      w_rr_ptr_nxt = w_ptr_after;
    end
  end

  // Grant, pulse and pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gnt       <= '0;
      r_gnt_idx   <= '0;
      r_gnt_valid <= 1'b0;
      r_done      <= 1'b0;
      r_timeout   <= 1'b0;
      r_rr_ptr    <= '0;
    end else begin
      r_gnt       <= w_gnt_nxt;
      r_gnt_idx   <= w_gnt_idx_nxt;
      r_gnt_valid <= (w_state_nxt == ARB_BUSY);
      r_done      <= w_done_nxt;
      r_timeout   <= w_timeout_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
    end
  end

  assign bus.gnt_o       = r_gnt;
  assign bus.gnt_idx_o   = r_gnt_idx;
  assign bus.gnt_valid_o = r_gnt_valid;
  assign bus.done_o      = r_done;
  assign bus.timeout_o   = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_uib_arbiter.sv
// ============================================================================
// Module  : tb_uib_arbiter
// Brief   : Directed self-checking bench for uib_arbiter (N_MASTER=4,
//           TIMEOUT=8). Covers both builds of UIB_ARB_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uib_arbiter;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  uib_arbiter_if #(.N_MASTER(4), .IDX_W(2)) bus ();

  uib_arbiter #(
    .N_MASTER (4),
    .IDX_W    (2),
    .TIMEOUT  (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle away from the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare all five outputs against expected values
  task automatic chk_out(input string tag, input logic [3:0] gnt, input logic [1:0] idx,
                         input logic valid, input logic done, input logic tmo);
    chk({tag, ".gnt"},   32'(bus.gnt_o),       32'(gnt));
    chk({tag, ".idx"},   32'(bus.gnt_idx_o),   32'(idx));
    chk({tag, ".valid"}, 32'(bus.gnt_valid_o), 32'(valid));
    chk({tag, ".done"},  32'(bus.done_o),      32'(done));
    chk({tag, ".tmo"},   32'(bus.timeout_o),   32'(tmo));
  endtask

  initial begin
    logic [1:0] e;
    errors            = 0;
    checks            = 0;
    rst               = 1'b1;
    bus.req_i         = 4'b1111;
    bus.slave_ready_i = 1'b0;

    // 1. Reset held two cycles with all requesting
    tick();
    tick();
    chk_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    chk_out("first_grant", 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0);

    // 2. Rotation 0,1,2,3,0 with one-cycle ready per grant
    for (int k = 0; k < 5; k++) begin
      e = 2'(k % 4);
      chk_out("rot_busy", 4'(1 << e), e, 1'b1, 1'b0, 1'b0);
      bus.slave_ready_i = 1'b1;
      tick();
      chk_out("rot_turn", 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0);
      bus.slave_ready_i = 1'b0;
      tick();
      chk_out("rot_idle", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
      tick();
    end

    // 3. Hold: m1 granted, m3 raises mid-BUSY, grant stays on m1
    bus.req_i = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_out("hold", 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0);
    end
    bus.slave_ready_i = 1'b1;
    tick();
    chk_out("hold_done", 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0);
    bus.slave_ready_i = 1'b0;
    bus.req_i         = 4'b1001;
    tick();
    tick();
    chk_out("skip_m3", 4'b1000, 2'd3, 1'b1, 1'b0, 1'b0);
    bus.slave_ready_i = 1'b1;
    tick();
    chk_out("skip_done", 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0);
    bus.slave_ready_i = 1'b0;

    // 4. Abort: m2 granted then withdraws before ready
    bus.req_i = 4'b0100;
    tick();
    tick();
    chk_out("abort_gnt", 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0);
    bus.req_i         = 4'b0000;
    bus.slave_ready_i = 1'b1;
    tick();
    chk_out("abort_turn", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    bus.slave_ready_i = 1'b0;
    tick();
    chk_out("abort_idle", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    bus.req_i = 4'b1111;
    tick();
    chk_out("after_abort", 4'b1000, 2'd3, 1'b1, 1'b0, 1'b0);
    bus.slave_ready_i = 1'b1;
    tick();
    bus.slave_ready_i = 1'b0;
    tick();
    tick();
    chk_out("tmo_gnt", 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0);

    // 5. No ready: forced release or indefinite hold depending on build
`ifdef UIB_ARB_TIMEOUT_EN
    for (int k = 1; k < 8; k++) begin
      tick();
      chk_out("tmo_wait", 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0);
    end
    tick();
    chk_out("tmo_fire", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1);
    tick();
    chk_out("tmo_idle", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_out("tmo_next", 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0);
`else
    for (int k = 0; k < 120; k++) begin
      tick();
      chk("nomacro_valid", 32'(bus.gnt_valid_o), 32'd1);
      chk("nomacro_idx",   32'(bus.gnt_idx_o),   32'd0);
      chk("nomacro_tmo",   32'(bus.timeout_o),   32'd0);
    end
    bus.slave_ready_i = 1'b1;
    tick();
    chk_out("nomacro_done", 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0);
    bus.slave_ready_i = 1'b0;
    tick();
    tick();
    chk_out("nomacro_next", 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0);
`endif

    // 6. Reset mid-BUSY (pointer was 1): grant drops, pointer back to 0
    rst               = 1'b1;
    bus.slave_ready_i = 1'b1;
    tick();
    chk_out("rst_busy", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    rst               = 1'b0;
    bus.slave_ready_i = 1'b0;
    tick();
    chk_out("rst_regrant", 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
